// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and helpers for the 4-digit 7-segment scanner.
//   AN_OFF      : anode pattern with every digit dark (anodes are active-low)
//   NUM_DIGITS  : number of scanned digits (fixed at 4)
//   an_lookup   : digit index -> one-hot-low anode pattern
//   get_nibble  : extract the 4-bit nibble of a given digit from a 16-bit word
//   lz_blank    : leading-zero test for a digit (nibbles i..3 all zero, i >= 1)
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  function automatic logic [3:0] an_lookup(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = 4'b1110;
      2'd1:    an = 4'b1101;
      2'd2:    an = 4'b1011;
      2'd3:    an = 4'b0111;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

  function automatic logic [3:0] get_nibble(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = v[3:0];
      2'd1:    nib = v[7:4];
      2'd2:    nib = v[11:8];
      2'd3:    nib = v[15:12];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // Digit 0 is never a leading zero, so a value of zero still shows "0".
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] idx);
    logic z;
    case (idx)
      2'd0:    z = 1'b0;
      2'd1:    z = (v[15:4]  == 12'h000);
      2'd2:    z = (v[15:8]  == 8'h00);
      2'd3:    z = (v[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// -----------------------------------------------------------------------------
// seg_tick_gen
// Free-running prescaler that counts 0..TICK_DIV-1 and wraps. tick is high for
// exactly one cycle while the count sits at TICK_DIV-1, so the first tick edge
// after reset release is the TICK_DIV-th rising edge.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   tick : one-cycle strobe, once every TICK_DIV cycles
// -----------------------------------------------------------------------------
module seg_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Prescaler counter with wrap at TICK_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexing scanner for a 4-digit common-anode 7-segment display.
// A shadow copy of value/dp_en is captured only at the frame boundary (slot 3
// -> slot 0) so a frame never mixes two values. All outputs are registered and
// change only on the prescaler tick edge.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   value     : 16-bit hex value, digit0 = value[3:0]
//   dp_en     : per-digit decimal point request, active-high
//   blank_lz  : 1 = suppress leading zero digits
//   enable    : 0 = all anodes dark (scanning continues)
//   nibble    : nibble of the current digit, to the hex-to-segment decoder
//   seg_an    : anode selects, active-low
//   dp_n      : decimal point cathode, active-low
//   digit_idx : current digit slot
// -----------------------------------------------------------------------------
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [3:0]  nibble,
  output logic [3:0]  seg_an,
  output logic        dp_n,
  output logic [1:0]  digit_idx
);

  logic        w_tick;
  logic [1:0]  w_next_idx;
  logic        w_frame;
  logic [15:0] w_shadow_val_nxt;
  logic [3:0]  w_shadow_dp_nxt;
  logic        w_blank;
  logic [3:0]  w_nibble_nxt;
  logic [3:0]  w_seg_an_nxt;
  logic        w_dp_n_nxt;

  logic [1:0]  r_digit_idx;
  logic [15:0] r_shadow_val;
  logic [3:0]  r_shadow_dp;
  logic [3:0]  r_nibble;
  logic [3:0]  r_seg_an;
  logic        r_dp_n;

  seg_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_next_idx = r_digit_idx + 2'd1;
  assign w_frame    = (r_digit_idx == 2'(NUM_DIGITS - 1));

  // Next-slot computation: the outputs use the new index and, at a frame
  // boundary, the freshly captured shadow rather than the old one.
  always_comb begin
    w_shadow_val_nxt = r_shadow_val;
    w_shadow_dp_nxt  = r_shadow_dp;
    w_blank          = 1'b1;
    w_nibble_nxt     = 4'h0;
    w_seg_an_nxt     = AN_OFF;
    w_dp_n_nxt       = 1'b1;

    if (w_frame) begin
      w_shadow_val_nxt = value;
      w_shadow_dp_nxt  = dp_en;
    end else begin
      w_shadow_val_nxt = r_shadow_val;
      w_shadow_dp_nxt  = r_shadow_dp;
    end

    // Nibble is presented even for blanked digits.
    w_nibble_nxt = get_nibble(w_shadow_val_nxt, w_next_idx);
    w_blank      = !enable || (blank_lz && lz_blank(w_shadow_val_nxt, w_next_idx));

    if (w_blank) begin
      w_seg_an_nxt = AN_OFF;
      w_dp_n_nxt   = 1'b1;
    end else begin
      w_seg_an_nxt = an_lookup(w_next_idx);
      w_dp_n_nxt   = ~w_shadow_dp_nxt[w_next_idx];
    end
  end

  // Slot state and registered outputs, advanced only on the tick edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit_idx  <= 2'd3;
      r_shadow_val <= 16'h0000;
      r_shadow_dp  <= 4'b0000;
      r_nibble     <= 4'h0;
      r_seg_an     <= AN_OFF;
      r_dp_n       <= 1'b1;
    end else if (w_tick) begin
      r_digit_idx  <= w_next_idx;
      r_shadow_val <= w_shadow_val_nxt;
      r_shadow_dp  <= w_shadow_dp_nxt;
      r_nibble     <= w_nibble_nxt;
      r_seg_an     <= w_seg_an_nxt;
      r_dp_n       <= w_dp_n_nxt;
    end else begin
      r_digit_idx  <= r_digit_idx;
      r_shadow_val <= r_shadow_val;
      r_shadow_dp  <= r_shadow_dp;
      r_nibble     <= r_nibble;
      r_seg_an     <= r_seg_an;
      r_dp_n       <= r_dp_n;
    end
  end

  assign nibble    = r_nibble;
  assign seg_an    = r_seg_an;
  assign dp_n      = r_dp_n;
  assign digit_idx = r_digit_idx;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
// Directed bench for seg_scan_mux with TICK_DIV=4. Each slot's expected
// outputs are computed from a small behavioural model when the slot is
// started, queued, and compared when the tick edge delivers the new slot.
// Between ticks the outputs are checked to hold the previous slot's values.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       dpn;
    logic [1:0] idx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic        enable;
  logic [3:0]  nibble;
  logic [3:0]  seg_an;
  logic        dp_n;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  exp_t        prev;
  logic [1:0]  m_idx;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;

  seg_scan_mux #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .dp_en     (dp_en),
    .blank_lz  (blank_lz),
    .enable    (enable),
    .nibble    (nibble),
    .seg_an    (seg_an),
    .dp_n      (dp_n),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".seg_an"},    {12'h0, seg_an},    {12'h0, e.an});
    check({tag, ".nibble"},    {12'h0, nibble},    {12'h0, e.nib});
    check({tag, ".dp_n"},      {15'h0, dp_n},      {15'h0, e.dpn});
    check({tag, ".digit_idx"}, {14'h0, digit_idx}, {14'h0, e.idx});
  endtask

  task automatic model_reset();
    m_idx    = 2'd3;
    m_sh     = 16'h0000;
    m_dp     = 4'b0000;
    prev.an  = 4'b1111;
    prev.nib = 4'h0;
    prev.dpn = 1'b1;
    prev.idx = 2'd3;
    exp_q.delete();
  endtask

  // Advance one slot: model the next slot, hold-check the current one, then
  // compare on the tick edge.
  task automatic step_slot();
    exp_t        e;
    exp_t        got;
    logic [1:0]  nidx;
    logic [15:0] sh;
    logic        blank;
    nidx = m_idx + 2'd1;
    if (m_idx == 2'd3) begin
      m_sh = value;
      m_dp = dp_en;
    end
    sh    = m_sh >> (4 * nidx);
    blank = !enable || (blank_lz && nidx != 2'd0 && sh == 16'h0000);
    e.idx = nidx;
    e.nib = sh[3:0];
    e.an  = blank ? 4'b1111 : ~(4'b0001 << nidx);
    e.dpn = blank ? 1'b1 : ~m_dp[nidx];
    m_idx = nidx;
    exp_q.push_back(e);
    for (int k = 0; k < TICK_DIV - 1; k++) begin
      @(posedge clk);
      #1;
      check_out("hold", prev);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      got = exp_q.pop_front();
      check_out("slot", got);
      prev = got;
    end
  endtask

  initial begin
    rst      = 1'b1;
    value    = 16'h1234;
    dp_en    = 4'b0000;
    blank_lz = 1'b0;
    enable   = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", prev);
    @(negedge clk);
    rst = 1'b0;

    // 1. basic scan: first lit slot is digit0 with nibble 4
    step_slot();
    check("t1.first_an", {12'h0, seg_an}, 16'h000E);
    check("t1.first_nib", {12'h0, nibble}, 16'h0004);
    for (int s = 0; s < 5; s++) step_slot();   // digits 1,2,3,0,1

    // 2. tear-free capture: change while digit1 is shown
    value = 16'hABCD;
    step_slot();                                 // digit2 still '2'
    check("t2.old_digit2", {12'h0, nibble}, 16'h0002);
    step_slot();                                 // digit3 still '1'
    step_slot();                                 // digit0 'D'
    check("t2.new_digit0", {12'h0, nibble}, 16'h000D);
    for (int s = 0; s < 3; s++) step_slot();

    // 3. leading-zero blanking
    value    = 16'h0050;
    blank_lz = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step_slot();
      if (s == 2) check("t3.digit2_blank", {12'h0, seg_an}, 16'h000F);
    end
    value = 16'h0000;
    for (int s = 0; s < 4; s++) begin
      step_slot();
      if (s == 0) check("t3.zero_digit0_lit", {12'h0, seg_an}, 16'h000E);
    end

    // 4. decimal point, change made mid-frame
    blank_lz = 1'b0;
    value    = 16'h1234;
    for (int s = 0; s < 6; s++) step_slot();    // frame, then digits 0,1
    dp_en = 4'b0100;
    step_slot();                                 // digit2, old dp shadow
    check("t4.dp_not_yet", {15'h0, dp_n}, 16'h0001);
    for (int s = 0; s < 4; s++) step_slot();    // 3,0,1,2
    check("t4.dp_digit2", {15'h0, dp_n}, 16'h0000);
    step_slot();

    // 5. display disabled while scanning continues
    enable = 1'b0;
    for (int s = 0; s < 4; s++) step_slot();
    enable = 1'b1;
    step_slot();

    // 6. asynchronous reset mid-slot
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_out("async_rst", prev);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 5; s++) step_slot();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Time-multiplexing scanner for the 4-digit common-anode 7-segment display. It holds a 16-bit hex value and steps through the digits at a fixed refresh rate. For each digit it drives the active-low anode select and presents that digit's 4-bit nibble to the downstream hex-to-segment decoder, which produces the cathode pattern. It also handles per-digit decimal points, leading-zero blanking, global display enable, and frame-aligned (tear-free) value capture.

Parameters:
TICK_DIV, 100000, clk cycles per digit slot (1 kHz digit rate / 250 Hz frame at 100 MHz); legal range >= 2
NUM_DIGITS, 4, fixed at 4; not overridable in this revision

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
value  input  16  hex value to display; digit0 = value[3:0] (rightmost), digit3 = value[15:12]
dp_en  input  4  decimal-point request per digit, active-high, bit i = digit i
blank_lz  input  1  1 = suppress leading zero digits
enable  input  1  0 = all anodes off; scanning continues
nibble  output  4  hex nibble of the currently selected digit, to decoder input
seg_an  output  4  anode selects, active-low, one-hot-low when lit
dp_n  output  1  decimal-point cathode, active-low
digit_idx  output  2  index of the current digit slot

Behaviour:
- Async reset (rst=1), all flops at once:
  - prescaler=0, digit_idx=3, shadow value=16'h0000, shadow dp=4'b0000
  - nibble=4'h0, seg_an=4'b1111, dp_n=1
- Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle, when prescaler==TICK_DIV-1.
  - First tick after reset release occurs on the TICK_DIV-th rising edge.
- On tick edge:
  - digit_idx <= digit_idx+1 mod 4 (3 wraps to 0).
  - Frame boundary: if digit_idx==3 at the tick, shadow value <= value and shadow dp <= dp_en.
  - value and dp_en are sampled only at this edge; changes mid-frame are not shown until the next frame.
- Outputs are registered and load on the same tick edge as digit_idx, using the new index and the newly loaded shadow if a frame boundary occurs.
  - No glitches between ticks; outputs are constant for exactly TICK_DIV cycles per slot.
- Output rules for new index i:
  - nibble <= shadow[4i+3:4i], always, even when the digit is blanked.
  - Digit i is blanked if enable==0, or if blank_lz==1 and i>=1 and shadow nibbles i..3 are all zero. Digit 0 is never blanked by blank_lz (a value of 0 shows "0").
  - seg_an <= 4'b1111 if blanked, else all ones with bit i = 0.
  - dp_n <= 1 if blanked, else ~shadow_dp[i].
- enable and blank_lz are sampled at each tick; no mid-slot effect.
- Reset mid-scan: immediate return to reset state; anodes go dark asynchronously.
- Between ticks, all registers except the prescaler hold.

Decomposition:
- Shared package seg_pkg holds:
  - AN_OFF = 4'b1111
  - NUM_DIGITS = 4
  - anode one-hot-low lookup (digit index -> seg_an pattern)
- One sub-module, seg_tick_gen: parameterised prescaler with inputs clk, rst and output tick. Width = $clog2(TICK_DIV).
- Blanking logic and output registers stay in seg_scan_mux.

Test Plan:
(All scenarios use TICK_DIV=4.)
1. Reset, then value=16'h1234, enable=1, blank_lz=0, dp_en=0 -> the edge where seg_an first leaves 4'b1111 is 4 clk cycles after reset release; it gives seg_an=1110, nibble=4, dp_n=1. Each following 4-cycle slot gives 1101/3, 1011/2, 0111/1, then repeats.
2. Tear-free capture: value changes 16'h1234 -> 16'hABCD while digit_idx=1 -> digits 2 and 3 still show 2 and 1. At the next digit0 slot nibble=D, then C, B, A.
3. Leading-zero blanking: value=16'h0050, blank_lz=1 -> digit0 seg_an=1110 nibble=0, digit1 seg_an=1101 nibble=5, digit2 and digit3 seg_an=1111. With value=16'h0000, only digit0 is lit.
4. dp_en=4'b0100, value=16'h1234 -> dp_n=0 only during the digit2 slot (seg_an=1011). The dp_en change is only visible after the next frame boundary.
5. enable=0 -> seg_an=1111 and dp_n=1 in every slot, while digit_idx and nibble keep cycling 0..3. Re-asserting enable takes effect at the next tick.
6. Assert rst asynchronously mid-slot (between clock edges) -> seg_an=1111, dp_n=1, digit_idx=3, nibble=0 immediately. Release -> normal scanning restarts with digit0 after 4 cycles.
